// File: rtl/digit_scroll_display.sv
`default_nettype none
// ============================================================================
// Module   : digit_scroll_display
// Purpose  : Captures a strobed stream of 4-bit digit codes into a
//            NUM_DIGITS-deep scrolling window. Slot 0 is the newest digit and
//            is shown rightmost. The window is time-multiplexed onto a
//            common-anode seven-segment display. Slots that have not been
//            loaded are blanked. Codes 10..15 render as a dash.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-high reset
//            digit_in     - digit code (0..9 decimal, 10..15 invalid)
//            digit_valid  - one-cycle load strobe
//            clear        - synchronous flush of the window
//            an           - anode enables, active-low
//            seg          - segments {g,f,e,d,c,b,a}, active-low
//            frame_done   - one-cycle pulse when the scan returns to slot 0
//            fill         - number of loaded slots, saturating
// Revision : 1.0 - initial release
// ============================================================================
module digit_scroll_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            digit_in,
  input  logic                  digit_valid,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  frame_done,
  output logic [3:0]            fill
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int SCAN_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      C_REF_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      C_REF_ONE   = CNT_W'(1);
  localparam logic [SCAN_W-1:0]     C_SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]     C_SCAN_ONE  = SCAN_W'(1);
  localparam logic [3:0]            C_FILL_MAX  = 4'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] C_AN_ONE    = NUM_DIGITS'(1);
  localparam logic [6:0]            C_SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns; anything outside 0..9 shows a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase
    return pat;
  endfunction

  // Window state: one loaded flag and one code per slot.
  logic [NUM_DIGITS-1:0]      loaded_q, loaded_d;
  logic [NUM_DIGITS-1:0][3:0] code_q,   code_d;
  logic [3:0]                 count_q,  count_d;

  // Scan state.
  logic [CNT_W-1:0]           ref_q,    ref_d;
  logic [SCAN_W-1:0]          scan_q,   scan_d;
  logic                       wrap_q,   wrap_d;

  // Registered outputs.
  logic [NUM_DIGITS-1:0]      an_q,     an_d;
  logic [6:0]                 seg_q,    seg_d;
  logic                       fdone_q,  fdone_d;
  logic [3:0]                 fill_q,   fill_d;

  logic                       ref_wrap;
  logic                       sel_loaded;
  logic [3:0]                 sel_code;

  // Window shift: clear dominates a coincident load.
  always_comb begin
    loaded_d = loaded_q;
    code_d   = code_q;
    count_d  = count_q;
    if (clear) begin
      loaded_d = '0;
      count_d  = 4'd0;
    end else if (digit_valid) begin
      loaded_d = {loaded_q[NUM_DIGITS-2:0], 1'b1};
      code_d   = {code_q[NUM_DIGITS-2:0], digit_in};
      if (count_q != C_FILL_MAX) begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // Refresh counter and scan index.
  always_comb begin
    ref_wrap = (ref_q == C_REF_LAST);
    ref_d    = ref_wrap ? '0 : ref_q + C_REF_ONE;
    scan_d   = scan_q;
    if (ref_wrap) begin
      scan_d = (scan_q == C_SCAN_LAST) ? '0 : scan_q + C_SCAN_ONE;
    end
    // Marks the edge on which the scan leaves the last slot; the output
    // stage shows slot 0 one edge later, which is when frame_done fires.
    wrap_d = ref_wrap && (scan_q == C_SCAN_LAST);
  end

  // Output stage samples the current window and scan slot, so a load is
  // visible on the display one cycle after it lands in the window.
  always_comb begin
    sel_loaded = loaded_q[scan_q];
    sel_code   = code_q[scan_q];
    an_d       = sel_loaded ? ~(C_AN_ONE << scan_q) : '1;
    seg_d      = sel_loaded ? f_decode(sel_code) : C_SEG_BLANK;
    fdone_d    = wrap_q;
    fill_d     = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= '0;
      code_q   <= '0;
      count_q  <= 4'd0;
      ref_q    <= '0;
      scan_q   <= '0;
      wrap_q   <= 1'b0;
      an_q     <= '1;
      seg_q    <= C_SEG_BLANK;
      fdone_q  <= 1'b0;
      fill_q   <= 4'd0;
    end else begin
      loaded_q <= loaded_d;
      code_q   <= code_d;
      count_q  <= count_d;
      ref_q    <= ref_d;
      scan_q   <= scan_d;
      wrap_q   <= wrap_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fdone_q  <= fdone_d;
      fill_q   <= fill_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fdone_q;
  assign fill       = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scroll_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scroll_display
// Purpose  : Self-checking bench for digit_scroll_display. A reference model
//            tracks the window as a queue of digits and the scan position as
//            a plain edge count; it queues the expected outputs for every
//            clock edge and a separate monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scroll_display;

  localparam int N   = 4;
  localparam int DIV = 4;

  localparam logic [6:0] DEC [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fd;
    logic [3:0]   fill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   digit_in;
  logic         digit_valid;
  logic         clear;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         frame_done;
  logic [3:0]   fill;

  int n_pass  = 0;
  int n_total = 0;

  exp_t sb[$];

  digit_scroll_display #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .clear      (clear),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // win[0] is the newest digit; edges counts non-reset edges since reset.
  int win[$];
  int edges = 0;

  always @(posedge clk) begin
    exp_t x;
    int   s;
    if (rst) begin
      x.an   = '1;
      x.seg  = 7'h7F;
      x.fd   = 1'b0;
      x.fill = 4'd0;
      win.delete();
      edges = 0;
    end else begin
      s      = (edges / DIV) % N;
      x.fill = 4'(win.size());
      x.fd   = (edges > 0) && (edges % (N * DIV) == 0);
      if (s < win.size()) begin
        x.an  = ~(N'(1) << s);
        x.seg = DEC[win[s]];
      end else begin
        x.an  = '1;
        x.seg = 7'h7F;
      end
      if (clear) begin
        win.delete();
      end else if (digit_valid) begin
        win.push_front(int'(digit_in));
        if (win.size() > N) void'(win.pop_back());
      end
      edges++;
    end
    sb.push_back(x);
  end

  // ---------------- monitor ----------------
  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("an",         int'(an),         int'(x.an));
      check("seg",        int'(seg),        int'(x.seg));
      check("frame_done", int'(frame_done), int'(x.fd));
      check("fill",       int'(fill),       int'(x.fill));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int d);
    digit_in    = 4'(d);
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
  endtask

  initial begin
    int seq_a[4] = '{9, 8, 6, 6};
    int seq_b[6] = '{5, 6, 2, 4, 1, 8};

    rst         = 1'b1;
    digit_in    = 4'd5;
    digit_valid = 1'b0;
    clear       = 1'b0;

    // Reset held three cycles while digit_valid toggles.
    for (int i = 0; i < 3; i++) begin
      digit_valid = ~digit_valid;
      step(1);
    end
    rst         = 1'b0;
    digit_valid = 1'b0;
    step(N * DIV);

    // Phone sequence, back to back.
    foreach (seq_a[i]) load(seq_a[i]);
    step(N * DIV);
    foreach (seq_b[i]) load(seq_b[i]);
    step(N * DIV);

    // Partial fill.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    load(7);
    step(N * DIV);

    // Invalid code, then clear racing a load.
    load(12);
    step(DIV);
    digit_in    = 4'd3;
    digit_valid = 1'b1;
    clear       = 1'b1;
    step(1);
    digit_valid = 1'b0;
    clear       = 1'b0;
    step(N * DIV);

    // Idle refresh.
    step(40);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 600; i++) begin
      digit_valid = ($urandom_range(0, 2) != 0);
      digit_in    = 4'($urandom_range(0, 15));
      clear       = ($urandom_range(0, 24) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst         = 1'b0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    step(N * DIV + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
